// File: rtl/jls_pkg.sv
// Shared definitions for the JPEG-LS frame scheduler.
// Provides the FSM state type, encoder-port widths, the image-size legality
// bounds, the latched-dimension payload and a size-check helper.
package jls_pkg;

    localparam int unsigned JLS_REQ_W_BITS = 15;
    localparam int unsigned JLS_REQ_H_BITS = 14;
    localparam int unsigned JLS_DIM_BITS   = 14;
    localparam int unsigned JLS_PIX_BITS   = 8;
    localparam int unsigned JLS_CNT_BITS   = 28;
    localparam int unsigned JLS_INFL_BITS  = 3;

    localparam int unsigned JLS_W_MIN = 5;
    localparam int unsigned JLS_W_MAX = 16384;
    localparam int unsigned JLS_H_MAX = 16383;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SOF  = 2'd1,
        ST_PIX  = 2'd2,
        ST_GAP  = 2'd3
    } jls_state_e;

    // Dimensions as the encoder wants them (value minus one)
    typedef struct packed {
        logic [JLS_DIM_BITS-1:0] w_m1;
        logic [JLS_DIM_BITS-1:0] h_m1;
    } jls_dims_t;

    // True when the requested image size is one the encoder core supports
    function automatic logic jls_size_legal(input logic [JLS_REQ_W_BITS-1:0] w,
                                            input logic [JLS_REQ_H_BITS-1:0] h);
        return (w >= JLS_REQ_W_BITS'(JLS_W_MIN)) &&
               (w <= JLS_REQ_W_BITS'(JLS_W_MAX)) &&
               (h != '0) &&
               ({1'b0, h} <= JLS_REQ_W_BITS'(JLS_H_MAX));
    endfunction

endpackage

// File: rtl/jls_frame_scheduler_if.sv
// Bundle of the scheduler's descriptor, pixel, encoder and status signals.
//   slave  : scheduler side (takes descriptors/pixels, drives the encoder)
//   master : environment side (producers, encoder monitor taps)
interface jls_frame_scheduler_if;
    import jls_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic [JLS_REQ_W_BITS-1:0] req_w;
    logic [JLS_REQ_H_BITS-1:0] req_h;
    logic                      pix_valid;
    logic                      pix_ready;
    logic [JLS_PIX_BITS-1:0]   pix_x;
    logic                      enc_sof;
    logic [JLS_DIM_BITS-1:0]   enc_w;
    logic [JLS_DIM_BITS-1:0]   enc_h;
    logic                      enc_e;
    logic [JLS_PIX_BITS-1:0]   enc_x;
    logic                      enc_o_e;
    logic                      enc_o_last;
    logic                      busy;
    logic                      err_size;

    modport slave (
        input  req_valid, req_w, req_h, pix_valid, pix_x, enc_o_e, enc_o_last,
        output req_ready, pix_ready, enc_sof, enc_w, enc_h, enc_e, enc_x, busy, err_size
    );

    modport master (
        output req_valid, req_w, req_h, pix_valid, pix_x, enc_o_e, enc_o_last,
        input  req_ready, pix_ready, enc_sof, enc_w, enc_h, enc_e, enc_x, busy, err_size
    );

endinterface

// File: rtl/jls_frame_scheduler.sv
// Sequences frames into the JPEG-LS encoder: start-of-frame preamble,
// raster pixels, then an idle gap. Caps frames in flight inside the encoder
// by watching its end-of-stream marker and rejects unsupported sizes.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - jls_frame_scheduler_if.slave (descriptor, pixel, encoder, status)
module jls_frame_scheduler
    import jls_pkg::*;
#(
    parameter int unsigned SOF_CYCLES   = 368,
    parameter int unsigned GAP_CYCLES   = 16,
    parameter int unsigned MAX_INFLIGHT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    jls_frame_scheduler_if.slave  bus
);

    localparam int unsigned TMR_MAX  = (SOF_CYCLES > GAP_CYCLES) ? SOF_CYCLES : GAP_CYCLES;
    localparam int unsigned TMR_BITS = $clog2(TMR_MAX + 1);

    jls_state_e                state_q, state_d;
    logic [TMR_BITS-1:0]       tmr_q, tmr_d;
    logic [JLS_CNT_BITS-1:0]   cnt_q, cnt_d;
    jls_dims_t                 dims_q, dims_d;
    logic [JLS_INFL_BITS-1:0]  infl_q, infl_d;

    logic                      req_ready_q, req_ready_d;
    logic                      pix_ready_q, pix_ready_d;
    logic                      enc_sof_q, enc_sof_d;
    logic [JLS_DIM_BITS-1:0]   enc_w_q, enc_w_d;
    logic [JLS_DIM_BITS-1:0]   enc_h_q, enc_h_d;
    logic                      enc_e_q, enc_e_d;
    logic [JLS_PIX_BITS-1:0]   enc_x_q, enc_x_d;
    logic                      busy_q, busy_d;
    logic                      err_q, err_d;

    logic                      req_fire;
    logic                      pix_fire;
    logic                      retire;
    logic                      size_ok;
    logic                      start;

    assign req_fire = bus.req_valid && req_ready_q;
    assign pix_fire = bus.pix_valid && pix_ready_q;
    assign retire   = bus.enc_o_e && bus.enc_o_last;
    assign size_ok  = jls_size_legal(bus.req_w, bus.req_h);

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        dims_d  = dims_q;
        infl_d  = infl_q;
        start   = 1'b0;
        err_d   = 1'b0;
        enc_e_d = 1'b0;
        enc_x_d = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    if (size_ok) begin
                        start       = 1'b1;
                        dims_d.w_m1 = JLS_DIM_BITS'(bus.req_w - JLS_REQ_W_BITS'(1));
                        dims_d.h_m1 = JLS_DIM_BITS'(bus.req_h - JLS_REQ_H_BITS'(1));
                        cnt_d       = JLS_CNT_BITS'(bus.req_w) * JLS_CNT_BITS'(bus.req_h);
                        tmr_d       = TMR_BITS'(SOF_CYCLES - 1);
                        state_d     = ST_SOF;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SOF: begin
                if (tmr_q == '0) begin
                    state_d = ST_PIX;
                end else begin
                    tmr_d = tmr_q - TMR_BITS'(1);
                end
            end
            ST_PIX: begin
                if (pix_fire) begin
                    enc_e_d = 1'b1;
                    enc_x_d = bus.pix_x;
                    cnt_d   = cnt_q - JLS_CNT_BITS'(1);
                    // The GAP timer also covers the cycle showing the last pixel
                    if (cnt_q == JLS_CNT_BITS'(1)) begin
                        state_d = ST_GAP;
                        tmr_d   = TMR_BITS'(GAP_CYCLES);
                    end
                end
            end
            ST_GAP: begin
                if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_BITS'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Start and retire in the same cycle cancel; retire at zero is ignored
        if (start && !retire) begin
            infl_d = infl_q + JLS_INFL_BITS'(1);
        end else if (!start && retire && (infl_q != '0)) begin
            infl_d = infl_q - JLS_INFL_BITS'(1);
        end

        req_ready_d = (state_d == ST_IDLE) && (32'(infl_d) < MAX_INFLIGHT);
        pix_ready_d = (state_d == ST_PIX);
        enc_sof_d   = (state_d == ST_SOF);
        enc_w_d     = enc_sof_d ? dims_d.w_m1 : '0;
        enc_h_d     = enc_sof_d ? dims_d.h_m1 : '0;
        busy_d      = (state_d != ST_IDLE) || (infl_d != '0);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            cnt_q       <= '0;
            dims_q      <= '0;
            infl_q      <= '0;
            req_ready_q <= 1'b0;
            pix_ready_q <= 1'b0;
            enc_sof_q   <= 1'b0;
            enc_w_q     <= '0;
            enc_h_q     <= '0;
            enc_e_q     <= 1'b0;
            enc_x_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            cnt_q       <= cnt_d;
            dims_q      <= dims_d;
            infl_q      <= infl_d;
            req_ready_q <= req_ready_d;
            pix_ready_q <= pix_ready_d;
            enc_sof_q   <= enc_sof_d;
            enc_w_q     <= enc_w_d;
            enc_h_q     <= enc_h_d;
            enc_e_q     <= enc_e_d;
            enc_x_q     <= enc_x_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.pix_ready = pix_ready_q;
    assign bus.enc_sof   = enc_sof_q;
    assign bus.enc_w     = enc_w_q;
    assign bus.enc_h     = enc_h_q;
    assign bus.enc_e     = enc_e_q;
    assign bus.enc_x     = enc_x_q;
    assign bus.busy      = busy_q;
    assign bus.err_size  = err_q;

endmodule

// File: tb/tb_jls_frame_scheduler.sv
// Self-checking bench for jls_frame_scheduler: a cycle-timeline model of the
// scheduler's observable behaviour is compared on every falling edge, plus
// hand-computed literal expectations for each directed scenario.
module tb_jls_frame_scheduler;

    localparam int SOF   = 368;
    localparam int GAP   = 16;
    localparam int MAXI  = 2;
    localparam int LIMIT = 20000;
    localparam int NEVER = 32'h3fff_ffff;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jls_frame_scheduler_if bus();

    jls_frame_scheduler #(
        .SOF_CYCLES   (SOF),
        .GAP_CYCLES   (GAP),
        .MAX_INFLIGHT (MAXI)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    bit   chk_en = 1'b0;
    int   cyc = 0;
    int   m_infl, sof_from, sof_to, pix_left, idle_from, e_cyc, err_cyc, rst_cyc, dw, dh;
    bit   pix_open;
    logic [7:0] e_x;
    int   x_req_ready, x_pix_ready, x_sof, x_w, x_h, x_e, x_busy, x_err;

    function automatic bit size_ok(input int w, input int h);
        return (w >= 5) && (w <= 16384) && (h >= 1) && (h <= 16383);
    endfunction

    always @(posedge clk) begin : model
        int  c, n;
        bit  inc, done;
        c   = cyc;
        inc = 1'b0;
        if (rst) begin
            m_infl = 0; sof_from = -10; sof_to = -10; pix_open = 1'b0; pix_left = 0;
            idle_from = c + 1; e_cyc = -10; err_cyc = -10; rst_cyc = c + 1;
            dw = 0; dh = 0; e_x = 8'd0;
            chk_en = 1'b1;
        end else if (chk_en) begin
            done = bus.enc_o_e && bus.enc_o_last;
            if (bus.req_valid && x_req_ready != 0) begin
                if (size_ok(int'(bus.req_w), int'(bus.req_h))) begin
                    inc = 1'b1;
                    sof_from = c + 1; sof_to = c + SOF;
                    pix_left = int'(bus.req_w) * int'(bus.req_h);
                    dw = int'(bus.req_w) - 1; dh = int'(bus.req_h) - 1;
                    idle_from = NEVER;
                end else begin
                    err_cyc = c + 1;
                end
            end
            if (inc && !done) m_infl++;
            else if (!inc && done && m_infl > 0) m_infl--;
            if (bus.pix_valid && x_pix_ready != 0) begin
                e_cyc = c + 1; e_x = bus.pix_x; pix_left--;
                if (pix_left == 0) begin
                    pix_open = 1'b0;
                    idle_from = c + GAP + 2;
                end
            end
        end
        cyc = cyc + 1;
        n = cyc;
        if (n == sof_to + 1) pix_open = 1'b1;
        x_sof       = (n >= sof_from && n <= sof_to) ? 1 : 0;
        x_w         = x_sof != 0 ? dw : 0;
        x_h         = x_sof != 0 ? dh : 0;
        x_pix_ready = pix_open ? 1 : 0;
        x_e         = (n == e_cyc) ? 1 : 0;
        x_err       = (n == err_cyc) ? 1 : 0;
        x_req_ready = (n != rst_cyc && n >= idle_from && m_infl < MAXI) ? 1 : 0;
        x_busy      = (n != rst_cyc && (n < idle_from || m_infl != 0)) ? 1 : 0;
    end

    // ---------------- per-cycle compare + monitors ----------------
    int sof_seen = 0, e_seen = 0, err_seen = 0, w_seen = -1, h_seen = -1;
    logic [7:0] sent_q[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(bus.req_ready), 32'(x_req_ready));
            check("pix_ready", 32'(bus.pix_ready), 32'(x_pix_ready));
            check("enc_sof",   32'(bus.enc_sof),   32'(x_sof));
            check("enc_w",     32'(bus.enc_w),     32'(x_w));
            check("enc_h",     32'(bus.enc_h),     32'(x_h));
            check("enc_e",     32'(bus.enc_e),     32'(x_e));
            if (x_e != 0) check("enc_x", 32'(bus.enc_x), 32'(e_x));
            check("busy",      32'(bus.busy),      32'(x_busy));
            check("err_size",  32'(bus.err_size),  32'(x_err));
            if (bus.enc_sof === 1'b1) begin
                sof_seen++; w_seen = int'(bus.enc_w); h_seen = int'(bus.enc_h);
            end
            if (bus.err_size === 1'b1) err_seen++;
            if (bus.enc_e === 1'b1) begin
                e_seen++;
                if (sent_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL enc_x_seq: got pixel %0d with none outstanding", bus.enc_x);
                end else begin
                    check("enc_x_seq", 32'(bus.enc_x), 32'(sent_q.pop_front()));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_req(input int w, input int h);
        int t;
        bus.req_valid = 1'b1; bus.req_w = 15'(w); bus.req_h = 14'(h);
        t = 0;
        do begin
            @(negedge clk); t++;
        end while (bus.req_ready !== 1'b1 && t < LIMIT);
        if (bus.req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL req_timeout: got no req_ready expected handshake for %0dx%0d", w, h);
        end
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic send_pixels(input int n, input int max_bub);
        int t, b;
        for (int i = 0; i < n; i++) begin
            b = (max_bub > 0) ? int'($urandom_range(max_bub, 0)) : 0;
            bus.pix_valid = 1'b0;
            repeat (b) step();
            bus.pix_valid = 1'b1; bus.pix_x = 8'($urandom);
            t = 0;
            do begin
                @(negedge clk); t++;
            end while (bus.pix_ready !== 1'b1 && t < LIMIT);
            if (bus.pix_ready !== 1'b1) begin
                checks++; errors++;
                $display("FAIL pix_timeout: got no pix_ready expected pixel %0d accepted", i);
                bus.pix_valid = 1'b0;
                return;
            end
            step();
            sent_q.push_back(bus.pix_x);
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        do begin
            @(negedge clk); t++;
        end while (bus.req_ready !== 1'b1 && t < LIMIT);
        if (bus.req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got req_ready 0 expected 1");
        end
        step();
    endtask

    task automatic retire();
        bus.enc_o_e = 1'b1; bus.enc_o_last = 1'b1;
        step();
        bus.enc_o_e = 1'b0; bus.enc_o_last = 1'b0;
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin : main
        int s0, e0, r0;
        bus.req_valid = 1'b0; bus.req_w = '0; bus.req_h = '0;
        bus.pix_valid = 1'b0; bus.pix_x = '0;
        bus.enc_o_e = 1'b0; bus.enc_o_last = 1'b0;

        // Reset, then req_ready rises one cycle after release
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("lit_rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("lit_rst_busy",      32'(bus.busy),      32'd0);
        @(negedge clk);
        check("lit_req_ready_up",  32'(bus.req_ready), 32'd1);
        step();

        // 5x1 frame, no bubbles
        s0 = sof_seen; e0 = e_seen;
        send_req(5, 1);
        send_pixels(5, 0);
        wait_ready();
        check("lit_5x1_sof_cycles", 32'(sof_seen - s0), 32'd368);
        check("lit_5x1_enc_w",      32'(w_seen),        32'd4);
        check("lit_5x1_enc_h",      32'(h_seen),        32'd0);
        check("lit_5x1_pixels",     32'(e_seen - e0),   32'd5);
        retire();

        // 64x48 frame with upstream bubbles
        e0 = e_seen;
        send_req(64, 48);
        send_pixels(3072, 2);
        wait_ready();
        check("lit_64x48_pixels", 32'(e_seen - e0),     32'd3072);
        check("lit_64x48_drain",  32'(sent_q.size()),   32'd0);
        retire();

        // Illegal sizes
        s0 = sof_seen; r0 = err_seen;
        send_req(4, 8);
        send_req(16385, 1);
        send_req(8, 0);
        step(); step();
        @(negedge clk);
        check("lit_err_pulses", 32'(err_seen - r0), 32'd3);
        check("lit_err_no_sof", 32'(sof_seen - s0), 32'd0);
        check("lit_err_busy",   32'(bus.busy),      32'd0);
        step();

        // In-flight cap: third frame stalls until one retire
        send_req(5, 1);
        send_pixels(5, 0);
        wait_ready();
        send_req(6, 1);
        send_pixels(6, 0);
        repeat (GAP + 5) step();
        bus.req_valid = 1'b1; bus.req_w = 15'd7; bus.req_h = 14'd1;
        repeat (20) step();
        @(negedge clk);
        check("lit_stall_req_ready", 32'(bus.req_ready), 32'd0);
        check("lit_stall_busy",      32'(bus.busy),      32'd1);
        step();
        retire();
        @(negedge clk);
        check("lit_unstall_req_ready", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 1'b0;
        send_pixels(7, 0);

        // Start and retire in the same cycle leave the count unchanged
        retire();
        wait_ready();
        bus.req_valid = 1'b1; bus.req_w = 15'd5; bus.req_h = 14'd1;
        bus.enc_o_e = 1'b1; bus.enc_o_last = 1'b1;
        step();
        bus.req_valid = 1'b0; bus.enc_o_e = 1'b0; bus.enc_o_last = 1'b0;
        send_pixels(5, 0);
        wait_ready();
        @(negedge clk);
        check("lit_same_cycle_busy", 32'(bus.busy), 32'd1);
        step();
        retire();
        @(negedge clk);
        check("lit_retired_busy", 32'(bus.busy), 32'd0);
        step();
        retire();
        @(negedge clk);
        check("lit_sat_busy",      32'(bus.busy),      32'd0);
        check("lit_sat_req_ready", 32'(bus.req_ready), 32'd1);
        step();

        // Reset in the middle of a frame, then a clean 8x8 frame
        send_req(16, 16);
        send_pixels(20, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("lit_midrst_req_ready", 32'(bus.req_ready), 32'd0);
        check("lit_midrst_pix_ready", 32'(bus.pix_ready), 32'd0);
        check("lit_midrst_enc_sof",   32'(bus.enc_sof),   32'd0);
        check("lit_midrst_enc_e",     32'(bus.enc_e),     32'd0);
        check("lit_midrst_busy",      32'(bus.busy),      32'd0);
        step();
        sent_q.delete();
        e0 = e_seen;
        send_req(8, 8);
        send_pixels(64, 0);
        wait_ready();
        check("lit_8x8_pixels", 32'(e_seen - e0), 32'd64);
        retire();
        @(negedge clk);
        check("lit_final_busy", 32'(bus.busy), 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jls_frame_scheduler.md
# jls_frame_scheduler

Sequences image frames into the JPEG-LS encoder core. Accepts frame descriptors and a pixel stream from upstream producers, then drives the encoder's frame-start/pixel input protocol: start-of-frame preamble, raster pixels, inter-frame idle gap. Limits how many frames are in flight inside the encoder by watching its end-of-stream marker, and rejects unsupported image sizes before they reach the core.

## Interface
- SOF_CYCLES, default 368: cycles `enc_sof` is held high per frame (encoder setup requirement).
- GAP_CYCLES, default 16: idle cycles after the last pixel of a frame.
- MAX_INFLIGHT, default 2: frames started but whose final output word (`enc_o_last`) has not yet been seen; range 1..7.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  frame descriptor valid.
- req_ready  out  1  descriptor accepted when `req_valid && req_ready`.
- req_w  in  15  image width in pixels (true value, not minus one).
- req_h  in  14  image height in pixels (true value).
- pix_valid  in  1  upstream pixel valid.
- pix_ready  out  1  scheduler accepts pixel.
- pix_x  in  8  pixel value, raster order.
- enc_sof  out  1  encoder start-of-frame.
- enc_w  out  14  width−1 to encoder, valid while `enc_sof`.
- enc_h  out  14  height−1 to encoder, valid while `enc_sof`.
- enc_e  out  1  encoder pixel strobe.
- enc_x  out  8  encoder pixel.
- enc_o_e  in  1  encoder output word valid (monitored only).
- enc_o_last  in  1  encoder last output word of a frame (monitored only).
- busy  out  1  state ≠ IDLE or in-flight count ≠ 0.
- err_size  out  1  one-cycle pulse: descriptor rejected.

## Operation
- States: IDLE, SOF, PIX, GAP.
- IDLE: `req_ready` = 1 iff inflight < MAX_INFLIGHT. On handshake:
  - size check: legal iff 5 ≤ w ≤ 16384 and 1 ≤ h ≤ 16383. Illegal → `err_size` pulse next cycle, stay IDLE, no encoder activity, inflight unchanged.
  - legal → latch w−1, h−1, load pixel count = w·h (28-bit), inflight += 1, go SOF.
- SOF: `enc_sof`=1, `enc_w/enc_h` = latched values, `enc_e`=0, for exactly SOF_CYCLES cycles; then PIX.
- PIX: `pix_ready`=1 (encoder has no backpressure). Each accepted pixel → `enc_e`=1, `enc_x`=pix_x next cycle; pixel count −1. `enc_sof`, `enc_w`, `enc_h` = 0. Upstream bubbles pass through as `enc_e`=0. On acceptance of the final pixel → GAP.
- GAP: all enc outputs 0 for GAP_CYCLES cycles, `pix_ready`=0; then IDLE.
- `pix_ready`=0 outside PIX; extra upstream pixels wait.
- Inflight counter (3 bits): +1 on legal accept, −1 on `enc_o_e && enc_o_last`; both same cycle → unchanged; decrement at 0 ignored (saturate).
- Width arithmetic: count = req_w × req_h computed once at accept, 15×14 → 29 bits, max 16384×16383 fits 28 bits.

## Timing
- All outputs registered. Reset values: `req_ready`=0, `pix_ready`=0, `enc_sof`=0, `enc_w`=0, `enc_h`=0, `enc_e`=0, `enc_x`=0, `busy`=0, `err_size`=0; state IDLE, inflight 0.
- `req_ready` first high the cycle after reset deasserts.
- Accept at cycle N → `enc_sof` high cycles N+1..N+SOF_CYCLES; `pix_ready` high from N+SOF_CYCLES+1.
- Pixel handshake at cycle M → `enc_e` high at M+1 (1-cycle latency, no reordering).
- Last pixel handshake at L → `pix_ready`=0 at L+1; `enc` idle L+2..L+1+GAP_CYCLES; `req_ready` may assert at L+GAP_CYCLES+2.
- Reset mid-frame: immediate return to reset values; encoder shares `rst`, so in-flight frames are discarded, inflight cleared.

## Structure
- Shared package `jls_pkg`: state enum, legality bounds (JLS_W_MIN=5, JLS_W_MAX=16384, JLS_H_MAX=16383), encoder-port widths (14-bit dims, 8-bit pixel).
- No sub-module; optional `jls_inflight_cnt` if reused by a multi-encoder arbiter.

## Test plan
- 5×1 frame, no bubbles → 368 `enc_sof` cycles with enc_w=4, enc_h=0, then 5 contiguous `enc_e`, 16 idle, `req_ready` back.
- 64×48 frame, random 0–2 upstream bubbles → exactly 3072 `enc_e` pulses, `enc_x` sequence matches input, each 1 cycle after handshake.
- Descriptors w=4,h=8 and w=16385,h=1 and w=8,h=0 → `err_size` pulse each, no `enc_sof`, inflight 0.
- MAX_INFLIGHT=2, three queued frames, no `enc_o_last` → third stalls (`req_ready`=0); one `enc_o_e && enc_o_last` → third starts next cycle.
- Increment and `enc_o_last` same cycle at inflight=1 → stays 1; `enc_o_last` at inflight 0 → stays 0.
- Assert `rst` mid-PIX → next cycle all outputs 0, `busy`=0; new 8×8 frame then completes normally.
